id_ex_stage_reg: RTL and testbench

- Pipeline register between decode (ID) and execute (EX).
- Captures decoded operands and ALU control, and drives the EX-stage ALU operand inputs (a, b, alu_op, sub_as_carry) straight from flops.
- Because mul/div/rem are combinational multicycle paths in EX, the block holds such ops for a programmable number of cycles before presenting them to MEM.
- Owns the ID->EX valid/ready handshake, flush, and multicycle stall generation.

---
 rtl/id_ex_stage_reg.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID->EX pipeline register.
// Registers the decoded operands and ALU control, and drives the EX ALU
// operand inputs straight from flops.
// Owns the ID->EX valid/ready handshake, flush, and the hold that covers
// combinational multicycle mul/div/rem.
// Optional feature macro: ID_EX_FORWARD_EN. When defined, a MEM-stage
// result is forwarded into a/b at the load edge.
module id_ex_stage_reg #(
   parameter int XLEN          = 64,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [3:0]      in_alu_op,
   input  logic            in_sub_as_carry,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [4:0]      in_rd,
   input  logic            in_wen,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic [3:0]      alu_op,
   output logic            sub_as_carry,
   output logic [4:0]      rd,
   output logic            wen,
   output logic [XLEN-1:0] pc,
   output logic            busy,
   input  logic [4:0]      fwd_rd,
   input  logic            fwd_wen,
   input  logic [XLEN-1:0] fwd_data
);

   // ALU opcodes that need the multicycle hold (para.v encoding).
   localparam logic [3:0] ALU_MUL = 4'd10;
   localparam logic [3:0] ALU_DIV = 4'd11;
   localparam logic [3:0] ALU_REM = 4'd12;

   // Counter just wide enough for MULDIV_CYCLES-1.
   localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MULDIV_CYCLES - 1);

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

   logic             full_q, full_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [XLEN-1:0]  a_q, a_d;
   logic [XLEN-1:0]  b_q, b_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic             sub_as_carry_q, sub_as_carry_d;
   logic [4:0]       rd_q, rd_d;
   logic             wen_q, wen_d;
   logic [XLEN-1:0]  pc_q, pc_d;

   logic [XLEN-1:0]  a_sel;
   logic [XLEN-1:0]  b_sel;
   logic             load;
   logic             drain;

   assign out_valid    = full_q && (hold_cnt_q == '0);
   assign busy         = full_q && (hold_cnt_q != '0);
   assign in_ready     = !full_q || (out_valid && out_ready);
   assign load         = in_valid && in_ready && !flush;
   assign drain        = out_valid && out_ready;

   assign a            = a_q;
   assign b            = b_q;
   assign alu_op       = alu_op_q;
   assign sub_as_carry = sub_as_carry_q;
   assign rd           = rd_q;
   assign wen          = wen_q;
   assign pc           = pc_q;

`ifdef ID_EX_FORWARD_EN
   // Operand select: forward the MEM result when it writes a source register.
   always_comb begin
      a_sel = in_a;
      b_sel = in_b;
      if (fwd_wen && (fwd_rd != 5'd0) && (fwd_rd == in_rs1)) a_sel = fwd_data;
      if (fwd_wen && (fwd_rd != 5'd0) && (fwd_rd == in_rs2)) b_sel = fwd_data;
   end
`else
   logic unused_fwd;
   assign a_sel      = in_a;
   assign b_sel      = in_b;
   assign unused_fwd = ^{fwd_rd, fwd_wen, fwd_data, in_rs1, in_rs2};
`endif

   // Next-state: flush wins over load, load wins over drain, hold counts down.
   always_comb begin
      full_d         = full_q;
      hold_cnt_d     = hold_cnt_q;
      a_d            = a_q;
      b_d            = b_q;
      alu_op_d       = alu_op_q;
      sub_as_carry_d = sub_as_carry_q;
      rd_d           = rd_q;
      wen_d          = wen_q;
      pc_d           = pc_q;
      if (flush) begin
         full_d     = 1'b0;
         hold_cnt_d = '0;
         wen_d      = 1'b0;
      end else if (load) begin
         full_d         = 1'b1;
         hold_cnt_d     = is_muldiv(in_alu_op) ? HOLD_INIT : '0;
         a_d            = a_sel;
         b_d            = b_sel;
         alu_op_d       = in_alu_op;
         sub_as_carry_d = in_sub_as_carry;
         rd_d           = in_rd;
         wen_d          = in_wen;
         pc_d           = in_pc;
      end else begin
         if (drain) begin
            full_d = 1'b0;
            wen_d  = 1'b0;
         end
         if (full_q && (hold_cnt_q != '0)) hold_cnt_d = hold_cnt_q - CNT_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q         <= 1'b0;
         hold_cnt_q     <= '0;
         a_q            <= '0;
         b_q            <= '0;
         alu_op_q       <= 4'd0;
         sub_as_carry_q <= 1'b0;
         rd_q           <= 5'd0;
         wen_q          <= 1'b0;
         pc_q           <= '0;
      end else begin
         full_q         <= full_d;
         hold_cnt_q     <= hold_cnt_d;
         a_q            <= a_d;
         b_q            <= b_d;
         alu_op_q       <= alu_op_d;
         sub_as_carry_q <= sub_as_carry_d;
         rd_q           <= rd_d;
         wen_q          <= wen_d;
         pc_q           <= pc_d;
      end
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg (XLEN=64, MULDIV_CYCLES=4).
module tb_id_ex_stage_reg;

   localparam int XLEN = 64;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_DIV = 4'd11;
   localparam logic [3:0] OP_REM = 4'd12;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_a, in_b, in_pc;
   logic [3:0]      in_alu_op;
   logic            in_sub_as_carry;
   logic [4:0]      in_rs1, in_rs2, in_rd;
   logic            in_wen;
   logic            flush;
   logic            out_ready;
   logic            out_valid;
   logic [XLEN-1:0] a, b, pc;
   logic [3:0]      alu_op;
   logic            sub_as_carry;
   logic [4:0]      rd;
   logic            wen;
   logic            busy;
   logic [4:0]      fwd_rd;
   logic            fwd_wen;
   logic [XLEN-1:0] fwd_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.XLEN(XLEN), .MULDIV_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_alu_op(in_alu_op),
      .in_sub_as_carry(in_sub_as_carry), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_wen(in_wen), .in_pc(in_pc), .flush(flush),
      .out_ready(out_ready), .out_valid(out_valid), .a(a), .b(b),
      .alu_op(alu_op), .sub_as_carry(sub_as_carry), .rd(rd), .wen(wen),
      .pc(pc), .busy(busy), .fwd_rd(fwd_rd), .fwd_wen(fwd_wen),
      .fwd_data(fwd_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [XLEN-1:0] va,
                           input logic [XLEN-1:0] vb, input logic [XLEN-1:0] vpc,
                           input logic [4:0] vrd, input logic vwen);
      in_valid        = 1'b1;
      in_alu_op       = op;
      in_a            = va;
      in_b            = vb;
      in_pc           = vpc;
      in_rd           = vrd;
      in_wen          = vwen;
      in_sub_as_carry = (op == OP_SUB);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_a = '0; in_b = '0; in_pc = '0; in_alu_op = OP_ADD;
      in_sub_as_carry = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
      in_wen = 1'b0; flush = 1'b0; out_ready = 1'b1;
      fwd_rd = 5'd0; fwd_wen = 1'b0; fwd_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      drive_op(OP_MUL, 64'hAAAA, 64'hBBBB, 64'h40, 5'd3, 1'b1);
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (a !== 64'd0 || b !== 64'd0) begin failures++; $display("FAIL reset_ab got a=%0h b=%0h exp=0", a, b); end
      checks++; if (wen !== 1'b0 || alu_op !== 4'd0) begin failures++; $display("FAIL reset_wen_op got wen=%0b op=%0d exp=0", wen, alu_op); end
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] ea, eb, epc;
      for (int i = 0; i < 3; i++) begin
         drive_op((i == 1) ? OP_SUB : OP_ADD, 64'(10 + i), 64'(20 + i),
                  64'(256 + 4 * i), 5'(i + 1), 1'b1);
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready%0d got=%0b exp=1", i, in_ready); end
         tick();
         ea = 64'(10 + i); eb = 64'(20 + i); epc = 64'(256 + 4 * i);
         checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_valid%0d got v=%0b busy=%0b exp v=1 busy=0", i, out_valid, busy); end
         checks++; if (a !== ea || b !== eb || pc !== epc) begin failures++; $display("FAIL b2b_data%0d got a=%0h b=%0h pc=%0h exp a=%0h b=%0h pc=%0h", i, a, b, pc, ea, eb, epc); end
         checks++; if (rd !== 5'(i + 1) || wen !== 1'b1 || sub_as_carry !== (i == 1)) begin failures++; $display("FAIL b2b_ctl%0d got rd=%0d wen=%0b sac=%0b", i, rd, wen, sub_as_carry); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || wen !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%0b wen=%0b exp 0/0", out_valid, wen); end
      checks++; if (a !== 64'd12 || b !== 64'd22) begin failures++; $display("FAIL b2b_keep_operands got a=%0h b=%0h exp a=c b=16", a, b); end
   endtask

   task automatic test_multicycle();
      drive_op(OP_DIV, 64'd100, 64'd7, 64'h500, 5'd9, 1'b1);
      tick();
      drive_op(OP_ADD, 64'd555, 64'd666, 64'h504, 5'd10, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mc_busy%0d got busy=%0b v=%0b rdy=%0b exp 1/0/0", k, busy, out_valid, in_ready); end
         checks++; if (a !== 64'd100 || b !== 64'd7 || alu_op !== OP_DIV) begin failures++; $display("FAIL mc_stable%0d got a=%0d b=%0d op=%0d exp 100/7/11", k, a, b, alu_op); end
         tick();
      end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || a !== 64'd100) begin failures++; $display("FAIL mc_done got v=%0b busy=%0b a=%0d exp 1/0/100", out_valid, busy, a); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mc_done_ready got=%0b exp=1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || a !== 64'd555 || pc !== 64'h504) begin failures++; $display("FAIL mc_next_load got v=%0b a=%0d pc=%0h exp 1/555/504", out_valid, a, pc); end
      // REM also takes the hold.
      drive_op(OP_REM, 64'd17, 64'd5, 64'h508, 5'd11, 1'b1);
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mc_rem_busy got busy=%0b v=%0b exp 1/0", busy, out_valid); end
      tick(); tick(); tick();
      checks++; if (out_valid !== 1'b1 || a !== 64'd17) begin failures++; $display("FAIL mc_rem_done got v=%0b a=%0d exp 1/17", out_valid, a); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mc_rem_drain got=%0b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive_op(OP_ADD, 64'd1, 64'd2, 64'h600, 5'd4, 1'b1);
      tick();
      drive_op(OP_ADD, 64'd3, 64'd4, 64'h604, 5'd5, 1'b1);
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall%0d got rdy=%0b v=%0b exp 0/1", k, in_ready, out_valid); end
         checks++; if (a !== 64'd1 || b !== 64'd2 || pc !== 64'h600) begin failures++; $display("FAIL bp_stable%0d got a=%0d b=%0d pc=%0h exp 1/2/600", k, a, b, pc); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || a !== 64'd3 || pc !== 64'h604) begin failures++; $display("FAIL bp_drain_load got v=%0b a=%0d pc=%0h exp 1/3/604", out_valid, a, pc); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      drive_op(OP_MUL, 64'd9, 64'd8, 64'h700, 5'd6, 1'b1);
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || wen !== 1'b1) begin failures++; $display("FAIL fl_busy1 got busy=%0b wen=%0b exp 1/1", busy, wen); end
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fl_busy2 got=%0b exp=1", busy); end
      flush = 1'b1;
      drive_op(OP_ADD, 64'd77, 64'd78, 64'h704, 5'd7, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || wen !== 1'b0) begin failures++; $display("FAIL fl_killed got v=%0b busy=%0b wen=%0b exp 0/0/0", out_valid, busy, wen); end
      checks++; if (in_ready !== 1'b1 || a !== 64'd9) begin failures++; $display("FAIL fl_ready got rdy=%0b a=%0d exp 1/9", in_ready, a); end
      // Flush into an empty stage drops the incoming instruction.
      flush = 1'b1;
      drive_op(OP_ADD, 64'd88, 64'd89, 64'h708, 5'd8, 1'b1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || a !== 64'd9 || wen !== 1'b0) begin failures++; $display("FAIL fl_drop got v=%0b a=%0d wen=%0b exp 0/9/0", out_valid, a, wen); end
      // Flush beats drain of a valid add.
      drive_op(OP_ADD, 64'd5, 64'd6, 64'h70c, 5'd9, 1'b1);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || wen !== 1'b0) begin failures++; $display("FAIL fl_valid_killed got v=%0b wen=%0b exp 0/0", out_valid, wen); end
   endtask

   task automatic test_forward();
      logic [XLEN-1:0] exp_a, exp_b;
      in_rs1 = 5'd5; in_rs2 = 5'd6;
      fwd_rd = 5'd5; fwd_wen = 1'b1; fwd_data = 64'hDEAD;
      drive_op(OP_ADD, 64'h1, 64'h2, 64'h800, 5'd1, 1'b1);
      tick();
`ifdef ID_EX_FORWARD_EN
      exp_a = 64'hDEAD;
`else
      exp_a = 64'h1;
`endif
      checks++; if (a !== exp_a || b !== 64'h2) begin failures++; $display("FAIL fwd_rs1 got a=%0h b=%0h exp a=%0h b=2", a, b, exp_a); end
      fwd_rd = 5'd0;
      tick();
      checks++; if (a !== 64'h1) begin failures++; $display("FAIL fwd_x0 got a=%0h exp=1", a); end
      fwd_rd = 5'd6; fwd_data = 64'hBEEF;
      tick();
`ifdef ID_EX_FORWARD_EN
      exp_b = 64'hBEEF;
`else
      exp_b = 64'h2;
`endif
      checks++; if (a !== 64'h1 || b !== exp_b) begin failures++; $display("FAIL fwd_rs2 got a=%0h b=%0h exp a=1 b=%0h", a, b, exp_b); end
      fwd_wen = 1'b0;
      tick();
      checks++; if (b !== 64'h2) begin failures++; $display("FAIL fwd_nowen got b=%0h exp=2", b); end
      idle_inputs();
      tick();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_multicycle();
      test_backpressure();
      test_flush();
      test_forward();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
